// File: rtl/johnson_pkg.sv
// Shared types and constants for the Johnson code monitor.
// Holds the FSM states and the code/index table.
package johnson_pkg;

    localparam int JOHNSON_W = 4;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Entry i is the Johnson word for position i.
    localparam logic [0:7][JOHNSON_W-1:0] CODE_TAB = {
        4'b0000, 4'b1000, 4'b1100, 4'b1110,
        4'b1111, 4'b0111, 4'b0011, 4'b0001
    };

endpackage

// File: rtl/johnson_rx_monitor_if.sv
// Code stream in, decode and lock status out.
// Master drives samples, slave is the monitor.
interface johnson_rx_monitor_if
    import johnson_pkg::*;
#(
    parameter int ERR_W = 8
);
    logic [JOHNSON_W-1:0] code_in;
    logic                 code_valid;
    logic [2:0]           index;
    logic                 index_valid;
    logic                 locked;
    logic                 dir;
    logic                 illegal;
    logic                 seq_err;
    logic [ERR_W-1:0]     err_count;

    modport master (
        output code_in, code_valid,
        input  index, index_valid, locked, dir,
        input  illegal, seq_err, err_count
    );

    modport slave (
        input  code_in, code_valid,
        output index, index_valid, locked, dir,
        output illegal, seq_err, err_count
    );
endinterface

// File: rtl/johnson_decode.sv
// Combinational Johnson word to position decoder.
// Flags the eight non-Johnson words as illegal.
module johnson_decode
    import johnson_pkg::*;
(
    input  logic [JOHNSON_W-1:0] code_in,
    output logic [2:0]           index,
    output logic                 legal
);
    // table lookup; at most one entry can match
    always_comb begin
        index = 3'd0;
        legal = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (code_in == CODE_TAB[i]) begin
                index = 3'(i);
                legal = 1'b1;
            end
        end
    end
endmodule

// File: rtl/johnson_rx_monitor.sv
// Johnson code stream monitor: lock, direction
// and error tracking over a sampled code stream.
module johnson_rx_monitor
    import johnson_pkg::*;
#(
    parameter int LOCK_COUNT = 3,
    parameter int ERR_W      = 8
) (
    input logic                 clk,
    input logic                 clr,
    johnson_rx_monitor_if.slave bus
);
    localparam logic [2:0] LC = 3'(LOCK_COUNT);

    state_t           state;
    logic [2:0]       idx_q;
    logic [2:0]       cnt_q;
    logic             iv_q;
    logic             lock_q;
    logic             dir_q;
    logic             ill_q;
    logic             seq_q;
    logic [ERR_W-1:0] err_q;

    logic [2:0]       dec_idx;
    logic             dec_legal;
    logic             fwd;
    logic             rev;
    logic             stall;
    logic             ahead;
    logic             step_ok;

    johnson_decode u_dec (
        .code_in (bus.code_in),
        .index   (dec_idx),
        .legal   (dec_legal)
    );

    // classify the new sample against the last legal position
    always_comb begin
        fwd     = dec_idx == idx_q + 3'd1;
        rev     = dec_idx == idx_q - 3'd1;
        stall   = dec_idx == idx_q;
        ahead   = dir_q ? rev : fwd;
        step_ok = (cnt_q == 3'd0) ? (fwd | rev) : ahead;
    end

    // sequencing FSM with registered outputs and error counter
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state  <= SEARCH;
            idx_q  <= 3'd0;
            cnt_q  <= 3'd0;
            iv_q   <= 1'b0;
            lock_q <= 1'b0;
            dir_q  <= 1'b0;
            ill_q  <= 1'b0;
            seq_q  <= 1'b0;
            err_q  <= '0;
        end else begin
            iv_q  <= 1'b0;
            ill_q <= 1'b0;
            seq_q <= 1'b0;
            if (bus.code_valid) begin
                if (!dec_legal) begin
                    ill_q  <= 1'b1;
                    state  <= SEARCH;
                    cnt_q  <= 3'd0;
                    lock_q <= 1'b0;
                    if (err_q != '1)
                        err_q <= err_q + ERR_W'(1);
                end else begin
                    idx_q <= dec_idx;
                    iv_q  <= 1'b1;
                    unique case (state)
                        SEARCH: begin
                            state <= ACQUIRE;
                            cnt_q <= 3'd0;
                        end
                        ACQUIRE: begin
                            if (stall) begin
                                cnt_q <= cnt_q;
                            end else if (step_ok) begin
                                if (cnt_q == 3'd0)
                                    dir_q <= rev;
                                if (cnt_q + 3'd1 == LC) begin
                                    state  <= LOCKED;
                                    lock_q <= 1'b1;
                                    cnt_q  <= 3'd0;
                                end else begin
                                    cnt_q <= cnt_q + 3'd1;
                                end
                            end else begin
                                cnt_q <= 3'd0;
                            end
                        end
                        LOCKED: begin
                            if (!(stall | ahead)) begin
                                seq_q  <= 1'b1;
                                lock_q <= 1'b0;
                                state  <= ACQUIRE;
                                cnt_q  <= 3'd0;
                                if (err_q != '1)
                                    err_q <= err_q + ERR_W'(1);
                            end
                        end
                        default: begin
                            state  <= SEARCH;
                            lock_q <= 1'b0;
                            cnt_q  <= 3'd0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.index       = idx_q;
    assign bus.index_valid = iv_q;
    assign bus.locked      = lock_q;
    assign bus.dir         = dir_q;
    assign bus.illegal     = ill_q;
    assign bus.seq_err     = seq_q;
    assign bus.err_count   = err_q;

endmodule

// File: tb/tb_johnson_rx_monitor.sv
// Bench for johnson_rx_monitor: directed scenarios
// plus random streams against a reference model.
module tb_johnson_rx_monitor;

    logic clk = 1'b0;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    johnson_rx_monitor_if #(.ERR_W(8)) bus ();
    johnson_rx_monitor_if #(.ERR_W(2)) sbus ();

    johnson_rx_monitor #(.LOCK_COUNT(3), .ERR_W(8)) u_dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    johnson_rx_monitor #(.LOCK_COUNT(3), .ERR_W(2)) u_sat (
        .clk (clk),
        .clr (clr),
        .bus (sbus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] tab [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                            4'b1111, 4'b0111, 4'b0011, 4'b0001};

    // reference model: mode 0 search, 1 acquire, 2 locked
    int m_mode, m_idx, m_steps, m_err;
    bit m_dir, e_iv, e_ill, e_seq;

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_steps = 0; m_err = 0;
        m_dir = 0; e_iv = 0; e_ill = 0; e_seq = 0;
    endtask

    task automatic model(input logic [3:0] c, input logic v);
        int d, delta, want;
        e_iv = 0; e_ill = 0; e_seq = 0;
        if (!v) return;
        d = -1;
        for (int k = 0; k < 8; k++) if (tab[k] == c) d = k;
        if (d < 0) begin
            e_ill = 1; m_mode = 0; m_steps = 0; m_err++;
            return;
        end
        e_iv = 1;
        delta = (d - m_idx + 8) % 8;
        want = m_dir ? 7 : 1;
        if (m_mode == 0) begin
            m_mode = 1; m_steps = 0;
        end else if (m_mode == 1) begin
            if (delta == 0) begin
            end else if ((delta == 1 || delta == 7) &&
                         (m_steps == 0 || delta == want)) begin
                if (m_steps == 0) m_dir = (delta == 7);
                m_steps++;
                if (m_steps == 3) begin m_mode = 2; m_steps = 0; end
            end else begin
                m_steps = 0;
            end
        end else begin
            if (delta != 0 && delta != want) begin
                e_seq = 1; m_err++; m_mode = 1; m_steps = 0;
            end
        end
        m_idx = d;
    endtask

    task automatic drive(input logic [3:0] c, input logic v);
        @(negedge clk);
        bus.code_in = c;  bus.code_valid = v;
        sbus.code_in = c; sbus.code_valid = v;
        @(posedge clk);
        model(c, v);
        #1;
        bus.code_valid = 1'b0;
        sbus.code_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b0;
        bus.code_valid = 1'b0;
        sbus.code_valid = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({bus.index, bus.index_valid, bus.locked, bus.dir,
             bus.illegal, bus.seq_err, bus.err_count} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got idx=%0d iv=%b lk=%b dir=%b ill=%b seq=%b err=%0d want all 0",
                     bus.index, bus.index_valid, bus.locked, bus.dir,
                     bus.illegal, bus.seq_err, bus.err_count);
        end
    endtask

    task automatic test_forward_lock();
        logic [3:0] seq [4] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(seq[i], 1'b1);
            n_cmp++;
            if (bus.locked !== (i == 3)) begin
                n_bad++;
                $display("FAIL fwd_locked step %0d: got %b want %b",
                         i, bus.locked, (i == 3));
            end
        end
        n_cmp++;
        if ({bus.dir, bus.index, bus.err_count} !== {1'b0, 3'd3, 8'd0}) begin
            n_bad++;
            $display("FAIL fwd_final: got dir=%b idx=%0d err=%0d want 0 3 0",
                     bus.dir, bus.index, bus.err_count);
        end
    endtask

    task automatic test_reverse_wrap();
        logic [3:0] seq [8] = '{4'b0011, 4'b0111, 4'b1111, 4'b1110,
                                4'b1100, 4'b1000, 4'b0000, 4'b0001};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(seq[i], 1'b1);
            n_cmp++;
            if (bus.locked !== (i >= 3) || bus.seq_err !== 1'b0) begin
                n_bad++;
                $display("FAIL rev_locked step %0d: got lk=%b seq=%b want lk=%b seq=0",
                         i, bus.locked, bus.seq_err, (i >= 3));
            end
        end
        n_cmp++;
        if ({bus.dir, bus.index, bus.err_count} !== {1'b1, 3'd7, 8'd0}) begin
            n_bad++;
            $display("FAIL rev_final: got dir=%b idx=%0d err=%0d want 1 7 0",
                     bus.dir, bus.index, bus.err_count);
        end
    endtask

    task automatic test_seq_err();
        logic [3:0] seq [4] = '{4'b0001, 4'b0000, 4'b1000, 4'b1100};
        logic [3:0] rel [3] = '{4'b0011, 4'b0001, 4'b0000};
        do_reset();
        foreach (seq[i]) drive(seq[i], 1'b1);
        drive(4'b0111, 1'b1);
        n_cmp++;
        if ({bus.seq_err, bus.locked, bus.err_count, bus.index, bus.index_valid}
            !== {1'b1, 1'b0, 8'd1, 3'd5, 1'b1}) begin
            n_bad++;
            $display("FAIL seq_err_pulse: got seq=%b lk=%b err=%0d idx=%0d iv=%b want 1 0 1 5 1",
                     bus.seq_err, bus.locked, bus.err_count, bus.index, bus.index_valid);
        end
        foreach (rel[i]) drive(rel[i], 1'b1);
        n_cmp++;
        if (bus.locked !== 1'b1) begin
            n_bad++;
            $display("FAIL seq_err_reacquire: got lk=%b want 1", bus.locked);
        end
    endtask

    task automatic test_illegal_stall();
        logic [3:0] seq [4] = '{4'b0001, 4'b0000, 4'b1000, 4'b1100};
        logic [3:0] rel [4] = '{4'b1110, 4'b1111, 4'b0111, 4'b0011};
        do_reset();
        foreach (seq[i]) drive(seq[i], 1'b1);
        for (int i = 0; i < 2; i++) begin
            drive(4'b1100, 1'b1);
            n_cmp++;
            if ({bus.locked, bus.seq_err, bus.illegal, bus.err_count, bus.index_valid}
                !== {1'b1, 1'b0, 1'b0, 8'd0, 1'b1}) begin
                n_bad++;
                $display("FAIL stall %0d: got lk=%b seq=%b ill=%b err=%0d iv=%b want 1 0 0 0 1",
                         i, bus.locked, bus.seq_err, bus.illegal, bus.err_count, bus.index_valid);
            end
        end
        drive(4'b1010, 1'b1);
        n_cmp++;
        if ({bus.illegal, bus.locked, bus.index, bus.err_count, bus.index_valid}
            !== {1'b1, 1'b0, 3'd2, 8'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL illegal_pulse: got ill=%b lk=%b idx=%0d err=%0d iv=%b want 1 0 2 1 0",
                     bus.illegal, bus.locked, bus.index, bus.err_count, bus.index_valid);
        end
        for (int i = 0; i < 4; i++) begin
            drive(rel[i], 1'b1);
            n_cmp++;
            if (bus.locked !== (i == 3)) begin
                n_bad++;
                $display("FAIL illegal_search step %0d: got lk=%b want %b",
                         i, bus.locked, (i == 3));
            end
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(4'b1010, 1'b1);
            n_cmp++;
            if (sbus.err_count !== exp[i] || sbus.illegal !== 1'b1) begin
                n_bad++;
                $display("FAIL sat_count %0d: got err=%0d ill=%b want %0d 1",
                         i, sbus.err_count, sbus.illegal, exp[i]);
            end
            drive(4'b0110, 1'b0);
            n_cmp++;
            if (sbus.err_count !== exp[i] || sbus.illegal !== 1'b0) begin
                n_bad++;
                $display("FAIL sat_gap %0d: got err=%0d ill=%b want %0d 0",
                         i, sbus.err_count, sbus.illegal, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_lock();
        logic [3:0] seq [5] = '{4'b1010, 4'b0011, 4'b0111, 4'b1111, 4'b1110};
        logic [3:0] rel [4] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
        do_reset();
        foreach (seq[i]) drive(seq[i], 1'b1);
        n_cmp++;
        if ({bus.locked, bus.dir, bus.err_count} !== {1'b1, 1'b1, 8'd1}) begin
            n_bad++;
            $display("FAIL pre_reset: got lk=%b dir=%b err=%0d want 1 1 1",
                     bus.locked, bus.dir, bus.err_count);
        end
        #2 clr = 1'b0;
        #1;
        n_cmp++;
        if ({bus.index, bus.index_valid, bus.locked, bus.dir,
             bus.illegal, bus.seq_err, bus.err_count} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got idx=%0d iv=%b lk=%b dir=%b err=%0d want all 0",
                     bus.index, bus.index_valid, bus.locked, bus.dir, bus.err_count);
        end
        model_reset();
        @(negedge clk);
        clr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(rel[i], 1'b1);
            n_cmp++;
            if (bus.locked !== (i == 3) || bus.index !== 3'(i + 1)) begin
                n_bad++;
                $display("FAIL post_reset step %0d: got lk=%b idx=%0d want %b %0d",
                         i, bus.locked, bus.index, (i == 3), i + 1);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] c;
        logic v;
        bit rd;
        int r, e_err;
        do_reset();
        rd = 0;
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 55) c = tab[(m_idx + (rd ? 7 : 1)) % 8];
            else if (r < 70) c = tab[m_idx];
            else if (r < 85) c = tab[$urandom_range(0, 7)];
            else c = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) rd = !rd;
            v = ($urandom_range(0, 9) != 0);
            drive(c, v);
            e_err = (m_err > 255) ? 255 : m_err;
            n_cmp++;
            if (bus.index !== 3'(m_idx) || bus.index_valid !== e_iv) begin
                n_bad++;
                $display("FAIL rnd_index %0d: got idx=%0d iv=%b want %0d %b",
                         n, bus.index, bus.index_valid, m_idx, e_iv);
            end
            n_cmp++;
            if (bus.illegal !== e_ill || bus.seq_err !== e_seq) begin
                n_bad++;
                $display("FAIL rnd_pulse %0d: got ill=%b seq=%b want %b %b",
                         n, bus.illegal, bus.seq_err, e_ill, e_seq);
            end
            n_cmp++;
            if (bus.locked !== (m_mode == 2) || bus.dir !== m_dir) begin
                n_bad++;
                $display("FAIL rnd_lock %0d: got lk=%b dir=%b want %b %b",
                         n, bus.locked, bus.dir, (m_mode == 2), m_dir);
            end
            n_cmp++;
            if (bus.err_count !== 8'(e_err)) begin
                n_bad++;
                $display("FAIL rnd_err %0d: got %0d want %0d",
                         n, bus.err_count, e_err);
            end
        end
    endtask

    initial begin
        bus.code_in = 4'b0000;  bus.code_valid = 1'b0;
        sbus.code_in = 4'b0000; sbus.code_valid = 1'b0;
        model_reset();
        test_reset();
        test_forward_lock();
        test_reverse_wrap();
        test_seq_err();
        test_illegal_stall();
        test_saturation();
        test_reset_mid_lock();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/johnson_rx_monitor.md
JOHNSON_RX_MONITOR -- requirements
Module: johnson_rx_monitor

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 3, meaning the number of consecutive correct steps needed to reach LOCKED (range 1..7).
REQ-002 SHALL have parameter ERR_W, default 8, meaning the width of the error counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port clr, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port code_in, input, 4 bits: 4-bit Johnson code word, bit 3 = first stage.
REQ-006 SHALL have port code_valid, input, 1 bit: code_in is sampled when high.
REQ-007 SHALL have port index, output, 3 bits: decoded position 0..7 of the last legal sample.
REQ-008 SHALL have port index_valid, output, 1 bit: one-cycle pulse, index updated.
REQ-009 SHALL have port locked, output, 1 bit: high while the FSM is in LOCKED.
REQ-010 SHALL have port dir, output, 1 bit: direction of the lock, 0 = forward, 1 = reverse.
REQ-011 SHALL have port illegal, output, 1 bit: one-cycle pulse, sampled code not a Johnson word.
REQ-012 SHALL have port seq_err, output, 1 bit: one-cycle pulse, legal code out of sequence while LOCKED.
REQ-013 SHALL have port err_count, output, ERR_W bits: saturating count of illegal plus seq_err events.

Function
REQ-014 SHALL decode the legal words as follows: 0000=0, 1000=1, 1100=2, 1110=3, 1111=4, 0111=5, 0011=6, 0001=7; the other 8 codes are illegal.
REQ-015 SHALL register every output, with one-cycle latency from the sampling edge (code_valid high) to index, index_valid, illegal and seq_err.
REQ-016 SHALL ignore code_in and hold all state when code_valid is low; pulses are low in that case.
REQ-017 SHALL implement the FSM states SEARCH, ACQUIRE and LOCKED.
REQ-018 SEARCH: a legal sample stores the reference index and moves to ACQUIRE with step count 0; an illegal sample pulses illegal and stays in SEARCH.
REQ-019 ACQUIRE, first step: a sample equal to the reference plus 1 mod 8 sets dir=0; a sample equal to the reference minus 1 mod 8 sets dir=1.
REQ-020 ACQUIRE: each correct step in the held dir increments the step count; reaching LOCK_COUNT moves to LOCKED.
REQ-021 ACQUIRE: a repeated identical code is a stall, with no step and no error.
REQ-022 ACQUIRE: any other legal code restarts ACQUIRE with that code as the reference and no error; an illegal code pulses illegal and moves to SEARCH.
REQ-023 LOCKED: the expected next index is index plus 1 mod 8 (dir=0) or index minus 1 mod 8 (dir=1); a match or a stall stays in LOCKED.
REQ-024 LOCKED: a legal mismatch pulses seq_err and moves to ACQUIRE with that code as the reference; an illegal code pulses illegal and moves to SEARCH.
REQ-025 Wrap-around SHALL be legal in both directions: 0001->0000 forward, 0000->0001 reverse.
REQ-026 index and index_valid SHALL update on every legal sample in all states; index holds its value on illegal samples.
REQ-027 err_count SHALL increment by 1 per illegal or seq_err pulse (never both in one cycle) and saturate at all-ones with no wrap.
REQ-028 locked SHALL drop in the same cycle that seq_err or illegal pulses.

Reset
REQ-029 While clr is low, the block SHALL immediately force: state SEARCH, index 0, index_valid 0, locked 0, dir 0, illegal 0, seq_err 0, err_count 0, step count 0.
REQ-030 Reset asserted mid-operation SHALL override any simultaneous sample; the first sample after deassertion is treated as a SEARCH sample.

Structure
REQ-031 A shared package johnson_pkg SHALL hold: the FSM state enum, the 8-entry code/index constant table, and the JOHNSON_W = 4 constant.
REQ-032 Code-to-index decoding SHALL be a combinational sub-module johnson_decode (code_in -> index, legal); sequencing and counters SHALL live in the top block.

Verification
REQ-033 Forward lock: after reset, feed 0000,1000,1100,1110 with code_valid=1 -> locked=1 one cycle after 1110 is sampled, dir=0, index=3, err_count=0.
REQ-034 Reverse with wrap: feed 0011,0111,1111,1110 -> locked=1, dir=1; then continue 1100,1000,0000,0001 -> stays locked, index=7, no error.
REQ-035 Sequence error: locked forward at index 2 (1100), feed 0111 -> seq_err pulse, locked=0, err_count=1, state ACQUIRE, index=5.
REQ-036 Illegal code and stall: locked, feed 1100 twice, then 1010 -> the repeat gives no error; 1010 pulses illegal, locked=0, SEARCH, index unchanged at 2.
REQ-037 Saturation and gaps: ERR_W=2, four illegal samples separated by code_valid=0 cycles -> err_count reads 1,2,3,3.
REQ-038 Reset mid-lock: assert clr low asynchronously while locked -> all outputs zero before the next clk edge; after release, 1000 alone -> ACQUIRE, locked=0.
